// File: rtl/memwb_pkg.sv
// memwb_pkg: shared definitions for the memory/write-back controller.
//   state_t  - FSM state encoding (IDLE, MEM, WB, HALTED)
//   REG_ZERO - hard-wired zero register; writes to it are suppressed
// Optional feature macro used by this slice: MEMWB_TIMEOUT_EN
package memwb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MEM    = 2'd1,
    WB     = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/memwb_ctrl_if.sv
// memwb_ctrl_if: bundles the execute-stage handshake, the data-memory
// request bus and the register-file write port of the MEM/WB controller.
//   slave  modport - seen by memwb_ctrl (takes instructions, drives memory/RF)
//   master modport - seen by the environment (execute stage, memory, RF)
// Optional feature macro used by this slice: MEMWB_TIMEOUT_EN (no effect here)
interface memwb_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  // execute-stage handshake and instruction fields
  logic              in_valid;
  logic              in_ready;
  logic              reg_we;
  logic              is_load;
  logic              is_store;
  logic              is_halt;
  logic [4:0]        dstreg_num;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] op2;
  // data memory request/ack bus
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;
  // register-file write port
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  modport slave (
    input  in_valid, reg_we, is_load, is_store, is_halt, dstreg_num,
           alu_result, op2, dmem_ack, dmem_rdata,
    output in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata,
           rf_we, rf_waddr, rf_wdata
  );

  modport master (
    output in_valid, reg_we, is_load, is_store, is_halt, dstreg_num,
           alu_result, op2, dmem_ack, dmem_rdata,
    input  in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata,
           rf_we, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/memwb_ctrl_timeout.sv
// memwb_timeout: wait-cycle counter for an outstanding memory request.
//   clk, rst    - clock and asynchronous active-high reset
//   clr         - restart the count (request just issued)
//   en          - one more cycle elapsed without an ack
//   expired     - this is the TIMEOUT_CYC-th cycle without an ack
// Only instantiated when MEMWB_TIMEOUT_EN is defined.
module memwb_timeout #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // next count: clear wins over increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q counts earlier ack-less cycles, so the current one is number cnt_q+1
  assign expired = en && (cnt_q == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/memwb_ctrl.sv
// memwb_ctrl: memory/write-back sequencing controller.
// Accepts one executed instruction at a time (in IDLE), runs a load/store
// over the req/ack data-memory bus, pulses the register-file write port with
// ALU or load data, or enters a sticky HALTED state.
//   clk, rst    - clock, asynchronous active-high reset
//   bus         - memwb_ctrl_if.slave: execute handshake, dmem bus, RF port
//   halted      - sticky halt indication
//   busy        - in MEM or WB
//   timeout_err - (MEMWB_TIMEOUT_EN only) sticky memory-timeout flag
// With MEMWB_TIMEOUT_EN defined, a request left unacknowledged for
// TIMEOUT_CYC cycles is abandoned and the controller halts.
import memwb_pkg::*;

module memwb_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
`ifdef MEMWB_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 16
`endif
) (
  input  logic         clk,
  input  logic         rst,
  memwb_ctrl_if.slave  bus,
  output logic         halted,
  output logic         busy
`ifdef MEMWB_TIMEOUT_EN
  , output logic       timeout_err
`endif
);

  state_t            state_q, state_d;
  logic [4:0]        dst_q, dst_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              we_q, we_d;
  logic              ld_wb_q, ld_wb_d;   // load that must write back

  logic accept_s;
  logic mem_entry_s;
  logic alu_wb_s;
  logic ld_done_s;
  logic tmo_s;

  assign accept_s    = bus.in_valid && (state_q == IDLE);
  assign mem_entry_s = accept_s && !bus.is_halt && (bus.is_load || bus.is_store);
  assign alu_wb_s    = accept_s && !bus.is_halt && !bus.is_load && !bus.is_store && bus.reg_we;
  assign ld_done_s   = (state_q == MEM) && bus.dmem_ack && !we_q && ld_wb_q;

`ifdef MEMWB_TIMEOUT_EN
  logic timeout_err_q, timeout_err_d;

  memwb_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (mem_entry_s),
    .en      ((state_q == MEM) && !bus.dmem_ack),
    .expired (tmo_s)
  );

  // sticky timeout flag
  always_comb begin
    timeout_err_d = timeout_err_q | tmo_s;
  end

  // timeout flag register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign tmo_s = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; halt beats load, load beats store, store beats ALU write
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!accept_s) begin
          state_d = IDLE;
        end else if (bus.is_halt) begin
          state_d = HALTED;
        end else if (bus.is_load || bus.is_store) begin
          state_d = MEM;
        end else if (bus.reg_we) begin
          state_d = WB;
        end else begin
          state_d = IDLE;
        end
      end
      MEM: begin
        if (bus.dmem_ack) begin
          state_d = ld_done_s ? WB : IDLE;
        end else if (tmo_s) begin
          state_d = HALTED;
        end else begin
          state_d = MEM;
        end
      end
      WB:      state_d = IDLE;
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  // datapath capture: fields latched when work is accepted, load data at ack
  always_comb begin
    dst_d      = dst_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    ld_wb_d    = ld_wb_q;
    rf_wdata_d = rf_wdata_q;
    if (mem_entry_s) begin
      dst_d   = bus.dstreg_num;
      addr_d  = bus.alu_result[ADDR_W-1:0];
      wdata_d = bus.op2;
      we_d    = !bus.is_load;
      ld_wb_d = bus.is_load && bus.reg_we;
    end else if (alu_wb_s) begin
      dst_d      = bus.dstreg_num;
      rf_wdata_d = bus.alu_result;
    end else if (ld_done_s) begin
      rf_wdata_d = bus.dmem_rdata;
    end else begin
      rf_wdata_d = rf_wdata_q;
    end
  end

  // datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dst_q      <= 5'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      ld_wb_q    <= 1'b0;
      rf_wdata_q <= '0;
    end else begin
      dst_q      <= dst_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      ld_wb_q    <= ld_wb_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // FSM outputs, decoded from the state register only
  always_comb begin
    bus.in_ready = (state_q == IDLE);
    bus.dmem_req = (state_q == MEM);
    bus.rf_we    = (state_q == WB) && (dst_q != REG_ZERO);
    halted       = (state_q == HALTED);
    busy         = (state_q == MEM) || (state_q == WB);
  end

  assign bus.dmem_we    = we_q;
  assign bus.dmem_addr  = addr_q;
  assign bus.dmem_wdata = wdata_q;
  assign bus.rf_waddr   = dst_q;
  assign bus.rf_wdata   = rf_wdata_q;

endmodule
